// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period derivation.
package uart_pkg;

  // Common state encoding for the receive and transmit FSMs.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Integer clocks per bit; truncation keeps the baud error tiny at 50 MHz / 9600.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/fpga_uart_if.sv
// Board-pin bundle between the FPGA and the Arduino serial link.
interface fpga_uart_if;
  logic       rx;
  logic       tx;
  logic [3:0] leds;

  // Board / Arduino side drives rx and observes tx and the LEDs.
  modport master (output rx, input tx, input leds);
  // FPGA side.
  modport slave  (input rx, output tx, output leds);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
//
//   state | meaning
//   IDLE  | line idle, waiting for a synchronized high-to-low edge
//   START | timing half a bit, then confirming the start bit is still low
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling the stop bit; on a framing error, waiting for line high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic          fall_edge;
  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bits_left_q;
  logic [7:0]    shift_q;
  logic          ferr_q;
  logic          valid_q;
  logic [7:0]    data_q;

  // Synchronize the asynchronous line and keep one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_edge = prev_q && !sync2_q;

  // Receive FSM: down-counter times each sample point, terminal count at zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_left_q <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ferr_q <= 1'b0;
          if (fall_edge) begin
            state_q <= START;
            cnt_q   <= HALF_TC;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!sync2_q) begin
            state_q     <= DATA;
            cnt_q       <= BIT_TC;
            bits_left_q <= 3'(DATA_BITS - 1);
          end else begin
            state_q <= IDLE;   // glitch shorter than half a bit
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= BIT_TC;
            if (bits_left_q == 3'd0) begin
              state_q <= STOP;
            end else begin
              bits_left_q <= bits_left_q - 1'b1;
            end
          end
        end
        STOP: begin
          if (ferr_q) begin
            if (sync2_q) begin
              state_q <= IDLE;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (sync2_q) begin
            valid_q <= 1'b1;
            data_q  <= shift_q;
            state_q <= IDLE;   // ready for the next start edge from mid-stop onward
          end else begin
            ferr_q <= 1'b1;    // byte discarded; hold here until the line recovers
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/fpga_uart_top.sv
// Arduino serial link: receive bytes, show low nibble on LEDs, echo each byte.
//
//   state | meaning (transmitter)
//   IDLE  | line high, waiting for a received or held byte
//   START | driving the start bit (0)
//   DATA  | driving 8 data bits, LSB first
//   STOP  | driving the stop bit (1)
module fpga_uart_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input logic        clk,
  input logic        rst_n,
  fpga_uart_if.slave pins
);

  localparam int            CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int            CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_TC       = CW'(CLKS_PER_BIT - 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [3:0]    leds_q;
  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bits_left_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (pins.rx),
    .data  (rx_data),
    .valid (rx_valid)
  );

  // LEDs follow every good byte, independent of the transmitter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      leds_q <= 4'b0000;
    end else if (rx_valid) begin
      leds_q <= rx_data[3:0];
    end
  end

  // Transmit FSM plus one-byte holding register; the held byte always goes out first.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_q     <= IDLE;
      tx_cnt_q       <= '0;
      tx_bits_left_q <= '0;
      tx_shift_q     <= '0;
      tx_q           <= 1'b1;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
    end else begin
      if (rx_valid) begin
        hold_q      <= rx_data;   // newest byte overwrites a full holding register
        hold_full_q <= 1'b1;
      end
      case (tx_state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (hold_full_q || rx_valid) begin
            tx_state_q  <= START;
            tx_q        <= 1'b0;
            tx_cnt_q    <= BIT_TC;
            tx_shift_q  <= hold_full_q ? hold_q : rx_data;
            hold_full_q <= hold_full_q && rx_valid;
          end
        end
        START: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end else begin
            tx_state_q     <= DATA;
            tx_q           <= tx_shift_q[0];
            tx_shift_q     <= {1'b0, tx_shift_q[7:1]};
            tx_bits_left_q <= 3'(DATA_BITS - 1);
            tx_cnt_q       <= BIT_TC;
          end
        end
        DATA: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end else if (tx_bits_left_q == 3'd0) begin
            tx_state_q <= STOP;
            tx_q       <= 1'b1;
            tx_cnt_q   <= BIT_TC;
          end else begin
            tx_q           <= tx_shift_q[0];
            tx_shift_q     <= {1'b0, tx_shift_q[7:1]};
            tx_bits_left_q <= tx_bits_left_q - 1'b1;
            tx_cnt_q       <= BIT_TC;
          end
        end
        STOP: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end else begin
            tx_state_q <= IDLE;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign pins.tx   = tx_q;
  assign pins.leds = leds_q;

endmodule

// File: tb/tb_fpga_uart_top.sv
// Directed bench for fpga_uart_top at a scaled-down bit period (16 clocks/bit).
`timescale 1ns/1ps
module tb_fpga_uart_top;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 16;
  localparam int HALF     = 8;

  logic clk = 1'b0;
  logic rst_n;

  fpga_uart_if bus ();

  fpga_uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // tx toggle counter
  int   tx_edges = 0;
  logic tx_prev  = 1'b1;
  always @(negedge clk) begin
    if (bus.tx !== tx_prev) tx_edges++;
    tx_prev = bus.tx;
  end

  // mid-bit sampler for echoed frames
  logic [7:0] echo_q[$];
  logic       echo_stop_q[$];
  initial begin : tx_monitor
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b0 && bus.tx === 1'b0) begin
        repeat (HALF) @(negedge clk);
        if (bus.tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx;
          end
          repeat (CPB) @(negedge clk);
          sb = bus.tx;
          echo_q.push_back(b);
          echo_stop_q.push_back(sb);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic [3:0] leds_before, input logic [3:0] leds_after,
                            input string tag);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (HALF) @(negedge clk);
    check_eq({tag, "_leds_pre"}, 32'(bus.leds), 32'(leds_before));
    repeat (5) @(negedge clk);
    check_eq({tag, "_leds_post"}, 32'(bus.leds), 32'(leds_after));
    repeat (CPB - HALF - 5) @(negedge clk);
  endtask

  task automatic wait_echo(input int n, input string tag);
    int k;
    k = 0;
    while (echo_q.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_echo_count"}, 32'(echo_q.size()), 32'(n));
  endtask

  initial begin
    int edges0;
    rst_n  = 1'b1;
    bus.rx = 1'b1;
    #50;
    check_eq("rst_tx", 32'(bus.tx), 32'd1);
    check_eq("rst_leds", 32'(bus.leds), 32'd0);
    #50;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("idle_tx", 32'(bus.tx), 32'd1);
    check_eq("idle_leds", 32'(bus.leds), 32'd0);
    check_eq("idle_tx_edges", 32'(tx_edges), 32'd0);

    // 0xCC
    send_frame(8'hCC, 1'b1, 4'h0, 4'hC, "cc");
    wait_echo(1, "cc");
    check_eq("cc_echo", 32'(echo_q[0]), 32'hCC);
    check_eq("cc_stop", 32'(echo_stop_q[0]), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("idle_between", 32'(bus.tx), 32'd1);

    // 0xAA
    send_frame(8'hAA, 1'b1, 4'hC, 4'hA, "aa");
    wait_echo(2, "aa");
    check_eq("aa_echo", 32'(echo_q[1]), 32'hAA);
    check_eq("aa_stop", 32'(echo_stop_q[1]), 32'd1);
    repeat (CPB * 2) @(negedge clk);

    // start glitch shorter than half a bit
    edges0 = tx_edges;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("glitch_leds", 32'(bus.leds), 32'hA);
    check_eq("glitch_tx_edges", 32'(tx_edges - edges0), 32'd0);
    check_eq("glitch_echo_count", 32'(echo_q.size()), 32'd2);

    // framing error on 0x5A
    edges0 = tx_edges;
    send_frame(8'h5A, 1'b0, 4'hA, 4'hA, "ferr");
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("ferr_echo_count", 32'(echo_q.size()), 32'd2);
    check_eq("ferr_tx_edges", 32'(tx_edges - edges0), 32'd0);
    check_eq("ferr_leds", 32'(bus.leds), 32'hA);

    // recovery after framing error
    send_frame(8'h03, 1'b1, 4'hA, 4'h3, "x03");
    wait_echo(3, "x03");
    check_eq("x03_echo", 32'(echo_q[2]), 32'h03);
    check_eq("x03_stop", 32'(echo_stop_q[2]), 32'd1);
    repeat (CPB * 2) @(negedge clk);

    // back-to-back frames, second byte waits in the holding register
    send_frame(8'h11, 1'b1, 4'h3, 4'h1, "b2b1");
    send_frame(8'h22, 1'b1, 4'h1, 4'h2, "b2b2");
    wait_echo(5, "b2b");
    check_eq("b2b_echo0", 32'(echo_q[3]), 32'h11);
    check_eq("b2b_echo1", 32'(echo_q[4]), 32'h22);
    check_eq("b2b_stop1", 32'(echo_stop_q[4]), 32'd1);
    check_eq("b2b_leds", 32'(bus.leds), 32'h2);
    repeat (CPB * 2) @(negedge clk);

    // reset during the echo start bit
    send_frame(8'h07, 1'b1, 4'h2, 4'h7, "rst7");
    check_eq("rst7_tx_low", 32'(bus.tx), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(bus.tx), 32'd1);
    check_eq("midrst_leds", 32'(bus.leds), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("post_rst_tx", 32'(bus.tx), 32'd1);
    check_eq("post_rst_leds", 32'(bus.leds), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_uart_top.md
# fpga_uart_top

Top-level FPGA block for the Arduino serial link. It receives 8N1 UART bytes at 9600 baud on `rx` and shows the low nibble of each good byte on four LEDs. It also echoes every good byte back on `tx`. It sits directly on the board pins, with no other logic between it and the Arduino.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD = 5208: derived integer; not overridden separately.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-high.
- `rx`  in  1  UART receive line from the Arduino; idle high; asynchronous to `clk`.
- `tx`  out  1  UART transmit line to the Arduino; idle high.
- `leds`  out  4  low nibble of the last good received byte.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge (high then low).
  - START: wait CLKS_PER_BIT/2 (2604) clocks, then resample.
    - Low: go to DATA.
    - High: glitch; return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, LSB first, 8 bits, then go to STOP.
  - STOP: sample one bit period later.
    - High: pulse `rx_valid` for 1 clock with the byte, then go to IDLE.
    - Low: framing error; discard the byte; wait for the line to return high, then go to IDLE.
- On `rx_valid`:
  - `leds` ← byte[3:0].
  - Byte is loaded into the transmitter.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - Each bit is held exactly CLKS_PER_BIT clocks.
  - Frame: start 0, 8 data bits LSB first, stop 1.
  - Returns to IDLE after the stop bit.
- Byte arriving while the transmitter is busy:
  - Stored in a one-byte holding register and sent immediately after the current frame.
  - If the holding register is already full, the newest byte overwrites it.
  - `leds` always update regardless of transmitter state.
- Reset values: `tx`=1, `leds`=4'b0000; both FSMs in IDLE; all counters 0; holding register empty.
- Reset mid-frame:
  - Aborts both FSMs immediately.
  - `tx` returns high asynchronously.
  - The partial byte is lost.

## Timing
- Bit period is 5208 clocks (104.16 µs at 50 MHz); baud error <0.01%.
- Receive detection delay: the falling edge is seen 2–3 clocks after the `rx` pin falls, due to the synchronizer.
- `rx_valid` fires at mid-stop-bit: about 9.5 bit periods plus 3 clocks after the start edge.
- `leds` update on the clock after `rx_valid`.
- `tx` start bit begins on the clock after `rx_valid` when the transmitter is idle.
- A full echo frame lasts 10 × 5208 = 52080 clocks.
- The receiver is ready for a new start bit from mid-stop-bit onward. Back-to-back frames with no idle gap are supported.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- Sub-module `uart_rx` holds the synchronizer and receive FSM.
  - Ports: `clk`, `rst_n`, `rx` in; `data[7:0]`, `valid` out.
- The transmitter, holding register and LED register live in the top.

## Test plan
- **Reset:** hold `rst_n`=1 for 100 ns with `rx`=1.
  - During reset: `tx`=1, `leds`=0000.
  - After release: `tx`=1, `leds`=0000, and `tx` does not toggle.
- **Receive 0xCC:** send 0xCC (8'b11001100) at 104167 ns/bit.
  - `leds`=1100 within 1 clock of mid-stop-bit.
  - `tx` echoes a frame; a mid-bit sampler reads 11001100 with a high stop bit.
- **Receive 0xAA:** then send 0xAA.
  - `leds`=1010.
  - Echoed byte reads 10101010.
  - `tx` is idle high between frames.
- **Start glitch:** drive `rx` low for 1 µs, then high.
  - No `leds` change; `tx` stays high.
- **Framing error:** send 0x5A with the stop bit driven 0.
  - `leds` unchanged; no echo.
  - A following 0x03 is received correctly: `leds`=0011 and 0x03 is echoed.
- **Back-to-back / reset:**
  - Send 0x11 then 0x22 with no gap: `leds` ends at 0010, and both 0x11 and 0x22 are echoed in order.
  - Assert reset mid-echo: `tx`=1 immediately and `leds`=0000.
